// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : kbd_pkg
// Brief   : Shared constants for the keyboard I/O-port controller: default
//           port addresses, command codes and status-byte bit positions.
// Rev     : 1.0  initial release
// ============================================================================
package kbd_pkg;

    // Default port addresses and interrupt vector
    localparam logic [15:0] c_PORT_DATA_DEF = 16'h0060;
    localparam logic [15:0] c_PORT_STAT_DEF = 16'h0064;
    localparam logic [7:0]  c_IRQ_VEC_DEF   = 8'h09;

    // Commands accepted on the status/command port
    localparam logic [7:0] c_CMD_RX_OFF  = 8'hAD;
    localparam logic [7:0] c_CMD_RX_ON   = 8'hAE;
    localparam logic [7:0] c_CMD_IRQ_ON  = 8'hA8;
    localparam logic [7:0] c_CMD_IRQ_OFF = 8'hA9;
    localparam logic [7:0] c_CMD_FLUSH   = 8'hFF;

    // Status byte bit positions
    localparam int c_STAT_OBF   = 0;
    localparam int c_STAT_RXEN  = 2;
    localparam int c_STAT_IRQEN = 3;
    localparam int c_STAT_OVF   = 4;

    // Assemble the status byte; unlisted bits read as zero
    function automatic logic [7:0] status_byte(input logic ovf,
                                               input logic irq_en,
                                               input logic rx_en,
                                               input logic obf);
        logic [7:0] s;
        s               = 8'h00;
        s[c_STAT_OBF]   = obf;
        s[c_STAT_RXEN]  = rx_en;
        s[c_STAT_IRQEN] = irq_en;
        s[c_STAT_OVF]   = ovf;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kbd_if.sv
`default_nettype none
// ============================================================================
// Module  : kbd_if
// Brief   : Bundle of the PS/2 receive strobe and the CPU port bus seen by
//           the keyboard controller. master = core/receiver side,
//           slave = controller side.
// Rev     : 1.0  initial release
// ============================================================================
interface kbd_if;
    logic [7:0]  kbd_data;
    logic        kbd_done;
    logic [15:0] port_a;
    logic        port_r;
    logic        port_w;
    logic [7:0]  port_o;
    logic [7:0]  port_i;
    logic        irq;
    logic [7:0]  irq_in;

    modport master (
        output kbd_data, kbd_done, port_a, port_r, port_w, port_o,
        input  port_i, irq, irq_in
    );

    modport slave (
        input  kbd_data, kbd_done, port_a, port_r, port_w, port_o,
        output port_i, irq, irq_in
    );
endinterface
`default_nettype wire

// File: rtl/kbd_fifo.sv
`default_nettype none
// ============================================================================
// Module  : kbd_fifo
// Brief   : Small byte FIFO with combinational head output. Pop on empty and
//           push on full are ignored, except that a push alongside a pop on a
//           full FIFO is accepted because the pop frees a slot. Flush wins
//           over push and pop.
// Rev     : 1.0  initial release
// ============================================================================
module kbd_fifo #(
    parameter int DEPTH = 16
) (
    input  wire logic                   clock,
    input  wire logic                   reset,
    input  wire logic                   push,
    input  wire logic                   pop,
    input  wire logic                   flush,
    input  wire logic [7:0]             din,
    output logic      [7:0]             dout,
    output logic                        empty,
    output logic                        full,
    output logic      [$clog2(DEPTH):0] count
);

    localparam int                c_AW      = $clog2(DEPTH);
    localparam logic [c_AW-1:0]   c_PTR_ONE = (c_AW)'(1);
    localparam logic [c_AW:0]     c_CNT_ONE = (c_AW+1)'(1);
    localparam logic [c_AW:0]     c_CNT_MAX = (c_AW+1)'(DEPTH);

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_do_pop;
    logic            w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_CNT_MAX);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            if (w_do_push && !w_do_pop)      r_count <= r_count + c_CNT_ONE;
            else if (w_do_pop && !w_do_push) r_count <= r_count - c_CNT_ONE;
        end
    end

    // Storage array; contents need no reset since occupancy gates visibility
    always_ff @(posedge clock) begin
        if (!reset && !flush && w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/kbd_port.sv
`default_nettype none
// ============================================================================
// Module  : kbd_port
// Brief   : Keyboard I/O-port controller. Queues PS/2 scancode bytes and
//           serves them to the core on the data port, with a status/command
//           port and a level interrupt while bytes are pending.
// Rev     : 1.0  initial release
// ============================================================================
module kbd_port
    import kbd_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [7:0]  IRQ_VEC   = c_IRQ_VEC_DEF,
    parameter logic [15:0] PORT_DATA = c_PORT_DATA_DEF,
    parameter logic [15:0] PORT_STAT = c_PORT_STAT_DEF
) (
    input wire logic clock,
    input wire logic reset,
    kbd_if.slave     bus
);

    logic                   r_rx_en;
    logic                   r_irq_en;
    logic                   r_ovf;
    logic [7:0]             r_last;
    logic                   r_irq;

    logic                   w_sel_data;
    logic                   w_sel_stat;
    logic                   w_rd_data;
    logic                   w_wr_stat;
    logic                   w_push_req;
    logic                   w_flush;
    logic                   w_popped;
    logic                   w_ovf_hit;
    logic [7:0]             w_head;
    logic                   w_empty;
    logic                   w_full;
    logic [$clog2(DEPTH):0] w_count;
    logic [7:0]             w_port_i;

    assign w_sel_data = (bus.port_a == PORT_DATA);
    assign w_sel_stat = (bus.port_a == PORT_STAT);
    assign w_rd_data  = bus.port_r && w_sel_data;
    assign w_wr_stat  = bus.port_w && w_sel_stat;
    assign w_push_req = bus.kbd_done && r_rx_en;
    assign w_flush    = w_wr_stat && (bus.port_o == c_CMD_FLUSH);
    assign w_popped   = w_rd_data && !w_empty;
    // A byte is lost only when full and no same-cycle pop makes room
    assign w_ovf_hit  = w_push_req && w_full && !w_popped;

    kbd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push_req),
        .pop   (w_rd_data),
        .flush (w_flush),
        .din   (bus.kbd_data),
        .dout  (w_head),
        .empty (w_empty),
        .full  (w_full),
        .count (w_count)
    );

    // Control/status registers, last-read byte and the registered interrupt
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_en  <= 1'b1;
            r_irq_en <= 1'b1;
            r_ovf    <= 1'b0;
            r_last   <= 8'h00;
            r_irq    <= 1'b0;
        end else begin
            if (w_popped) r_last <= w_head;

            if (w_flush)        r_ovf <= 1'b0;
            else if (w_ovf_hit) r_ovf <= 1'b1;

            if (w_wr_stat) begin
                case (bus.port_o)
                    c_CMD_RX_OFF:  r_rx_en  <= 1'b0;
                    c_CMD_RX_ON:   r_rx_en  <= 1'b1;
                    c_CMD_IRQ_ON:  r_irq_en <= 1'b1;
                    c_CMD_IRQ_OFF: r_irq_en <= 1'b0;
                    default:       ;
                endcase
            end

            r_irq <= r_irq_en && (w_count != '0);
        end
    end

    // Zero-latency read mux: data port shows head (or last byte when empty)
    always_comb begin
        w_port_i = 8'hFF;
        if (w_sel_data) begin
            w_port_i = w_empty ? r_last : w_head;
        end else if (w_sel_stat) begin
            w_port_i = status_byte(r_ovf, r_irq_en, r_rx_en, !w_empty);
        end
    end

    assign bus.port_i = w_port_i;
    assign bus.irq    = r_irq;
    assign bus.irq_in = IRQ_VEC;

endmodule
`default_nettype wire

// File: tb/tb_kbd_port.sv
`default_nettype none
// ============================================================================
// Module  : tb_kbd_port
// Brief   : Self-checking bench for kbd_port. Stimulus queues expected read
//           data and interrupt levels; a negedge monitor pops and compares.
// Rev     : 1.0  initial release
// ============================================================================
module tb_kbd_port;

    localparam logic [15:0] c_DATA = 16'h0060;
    localparam logic [15:0] c_STAT = 16'h0064;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kbd_if bus();

    kbd_port #(
        .DEPTH     (16),
        .IRQ_VEC   (8'h09),
        .PORT_DATA (c_DATA),
        .PORT_STAT (c_STAT)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int         total = 0;
    int         bad   = 0;
    logic [7:0] q_rd [$];
    string      t_rd [$];
    logic       q_irq [$];
    string      t_irq [$];
    logic       irq_chk = 1'b0;
    logic [7:0] m_exp;
    logic       m_irq;
    string      m_tag;

    // Monitor: compare DUT outputs whenever a read or an irq probe is active
    always @(negedge clk) begin
        if (!rst && bus.port_r) begin
            total++;
            if (q_rd.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: port_i=%02h, no expected value queued", bus.port_i);
            end else begin
                m_exp = q_rd.pop_front();
                m_tag = t_rd.pop_front();
                if (bus.port_i !== m_exp) begin
                    bad++;
                    $display("FAIL %s: port_i=%02h expected %02h", m_tag, bus.port_i, m_exp);
                end
            end
        end
        if (!rst && irq_chk) begin
            total++;
            if (q_irq.size() == 0) begin
                bad++;
                $display("FAIL irq_unexpected: irq=%b, no expected value queued", bus.irq);
            end else begin
                m_irq = q_irq.pop_front();
                m_tag = t_irq.pop_front();
                if (bus.irq !== m_irq || bus.irq_in !== 8'h09) begin
                    bad++;
                    $display("FAIL %s: irq=%b irq_in=%02h expected irq=%b irq_in=09",
                             m_tag, bus.irq, bus.irq_in, m_irq);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.kbd_done = 1'b0;
        bus.port_r   = 1'b0;
        bus.port_w   = 1'b0;
        irq_chk      = 1'b0;
    endtask

    task automatic do_push(input logic [7:0] b);
        bus.kbd_data = b;
        bus.kbd_done = 1'b1;
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] e, input string t);
        bus.port_a = a;
        bus.port_r = 1'b1;
        q_rd.push_back(e);
        t_rd.push_back(t);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] v);
        bus.port_a = a;
        bus.port_w = 1'b1;
        bus.port_o = v;
    endtask

    task automatic exp_irq(input logic e, input string t);
        irq_chk = 1'b1;
        q_irq.push_back(e);
        t_irq.push_back(t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, run incomplete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.kbd_data = 8'h00;
        bus.kbd_done = 1'b0;
        bus.port_a   = 16'h0000;
        bus.port_r   = 1'b0;
        bus.port_w   = 1'b0;
        bus.port_o   = 8'h00;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Strobes asserted in the last reset cycle must be ignored
        bus.kbd_data = 8'hAA;
        bus.kbd_done = 1'b1;
        bus.port_a   = c_STAT;
        bus.port_w   = 1'b1;
        bus.port_o   = 8'hAD;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.kbd_done = 1'b0;
        bus.port_w   = 1'b0;

        // 1: reset state
        do_read(c_STAT, 8'h0C, "rst_stat"); tick();
        do_read(c_DATA, 8'h00, "rst_data"); exp_irq(1'b0, "rst_irq"); tick();

        // 2: three bytes in order, irq timing, last-byte replay
        do_push(8'h1C); tick();
        do_push(8'hF0); exp_irq(1'b0, "t2_irq_lag"); tick();
        do_push(8'h1C); exp_irq(1'b1, "t2_irq_rise"); tick();
        do_read(c_DATA, 8'h1C, "t2_rd0"); tick();
        do_read(c_DATA, 8'hF0, "t2_rd1"); tick();
        do_read(c_DATA, 8'h1C, "t2_rd2"); tick();
        do_read(c_STAT, 8'h0C, "t2_stat_empty"); exp_irq(1'b1, "t2_irq_hold"); tick();
        do_read(c_DATA, 8'h1C, "t2_rd_last"); exp_irq(1'b0, "t2_irq_fall"); tick();

        // 3: overflow with 17 pushes, byte 10 lost
        for (int i = 0; i < 17; i++) begin
            do_push(8'(i)); tick();
        end
        do_read(c_STAT, 8'h1D, "t3_stat_ovf"); tick();
        for (int i = 0; i < 16; i++) begin
            do_read(c_DATA, 8'(i), "t3_drain"); tick();
        end
        do_read(c_DATA, 8'h0F, "t3_lost_byte"); tick();
        do_read(c_STAT, 8'h1C, "t3_ovf_sticky"); tick();
        do_write(c_STAT, 8'hFF); tick();
        do_read(c_STAT, 8'h0C, "t3_ovf_clr"); tick();

        // 4: push and pop together when full
        for (int i = 0; i < 16; i++) begin
            do_push(8'(8'h20 + i)); tick();
        end
        do_push(8'h55); do_read(c_DATA, 8'h20, "t4_full_pop"); tick();
        do_read(c_STAT, 8'h0D, "t4_no_ovf"); tick();
        do_push(8'h66); tick();
        do_read(c_STAT, 8'h1D, "t4_still_full"); tick();
        for (int i = 1; i < 16; i++) begin
            do_read(c_DATA, 8'(8'h20 + i), "t4_drain"); tick();
        end
        do_read(c_DATA, 8'h55, "t4_rd_55"); tick();
        do_read(c_DATA, 8'h55, "t4_rd_last"); tick();
        do_write(c_STAT, 8'hFF); tick();

        // 5: receive enable/disable and interrupt enable/disable
        do_write(c_STAT, 8'hAD); tick();
        do_push(8'h3A); tick();
        do_read(c_STAT, 8'h08, "t5_rx_off"); tick();
        do_read(c_DATA, 8'h55, "t5_no_push"); tick();
        do_write(c_STAT, 8'hAE); tick();
        do_push(8'h3A); tick();
        do_read(c_STAT, 8'h0D, "t5_rx_on"); exp_irq(1'b0, "t5_irq_lag"); tick();
        exp_irq(1'b1, "t5_irq_up"); tick();
        do_write(c_STAT, 8'hA9); tick();
        do_read(c_STAT, 8'h05, "t5_irq_en_off"); exp_irq(1'b1, "t5_a9_lag"); tick();
        do_read(c_STAT, 8'h05, "t5_obf_held"); exp_irq(1'b0, "t5_a9_drop"); tick();
        do_write(c_STAT, 8'hA8); tick();
        tick();
        exp_irq(1'b1, "t5_a8_up"); tick();
        do_read(c_DATA, 8'h3A, "t5_rd"); tick();
        do_push(8'h7E); do_read(c_DATA, 8'h3A, "t5_empty_pushpop"); tick();
        do_read(c_DATA, 8'h7E, "t5_after_pushpop"); tick();

        // 6: flush wins over a coincident push
        do_push(8'h11); tick();
        do_push(8'h22); tick();
        do_write(c_STAT, 8'hFF); do_push(8'h99); tick();
        do_read(c_STAT, 8'h0C, "t6_stat"); tick();
        do_read(c_DATA, 8'h7E, "t6_last"); exp_irq(1'b0, "t6_irq"); tick();

        // Misc: other address, ignored data-port write, read+write same cycle
        do_read(16'h0061, 8'hFF, "other_addr"); tick();
        do_write(c_DATA, 8'hAD); tick();
        do_read(c_STAT, 8'h0C, "data_wr_ignored"); tick();
        do_write(c_STAT, 8'hAD); do_read(c_STAT, 8'h0C, "rw_same_old"); tick();
        do_read(c_STAT, 8'h08, "rw_same_new"); tick();
        do_write(c_STAT, 8'hAE); tick();

        tick();
        total++;
        if (q_rd.size() != 0 || q_irq.size() != 0) begin
            bad++;
            $display("FAIL queues_drained: rd=%0d irq=%0d left, expected 0", q_rd.size(), q_irq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
